// File: rtl/nor_bank.sv
// -----------------------------------------------------------------------------
// nor_bank
//
// A bank of CHANNELS independent NOR gates. Each gate has INPUTS inputs, and
// each input has its own enable. Every gate output passes through three stages
// before it reaches y:
//   1. A persistence filter. A changed NOR value must hold for FILTER extra
//      sampling edges before it is accepted.
//   2. A pipeline of DELAY-1 extra register stages.
//   3. Change detection. chg pulses for one cycle when y takes a new value.
// A candidate change that collapses before acceptance is a "glitch". Each one
// produces a one-cycle pulse on glitch and bumps a per-channel 8-bit
// saturating counter.
//
// Parameters
//   CHANNELS  number of independent gates (1..32)
//   INPUTS    inputs per gate (1..16)
//   DELAY     register stages after the filter (1..16), 1 means y is the
//             filter state itself
//   FILTER    extra consecutive edges a change must persist (0..255)
//   IV        reset / initial value of each gate output
//
// Ports
//   clk         single clock, rising edge
//   rst_n       asynchronous active-low reset (deassertion synchronised
//               outside this block)
//   in          gate inputs, channel c at [c*INPUTS +: INPUTS]
//   en          per-input enable, same layout; a disabled input reads as 0
//   clr_cnt     synchronous clear of every glitch counter
//   y           delayed, filtered NOR results
//   chg         one-cycle pulse in the cycle y[c] shows a new value
//   glitch      one-cycle pulse when a candidate change on channel c dies
//   glitch_cnt  saturating rejected-change counts, channel c at [c*8 +: 8]
// -----------------------------------------------------------------------------
module nor_bank #(
    parameter int                  CHANNELS = 4,
    parameter int                  INPUTS   = 3,
    parameter int                  DELAY    = 1,
    parameter int                  FILTER   = 0,
    parameter logic [CHANNELS-1:0] IV       = '0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [CHANNELS*INPUTS-1:0] in,
    input  logic [CHANNELS*INPUTS-1:0] en,
    input  logic                       clr_cnt,
    output logic [CHANNELS-1:0]        y,
    output logic [CHANNELS-1:0]        chg,
    output logic [CHANNELS-1:0]        glitch,
    output logic [CHANNELS*8-1:0]      glitch_cnt
);

    // Stability counter width: wide enough to hold FILTER, never narrower
    // than one bit.
    localparam int            SW      = (FILTER > 0) ? $clog2(FILTER + 1) : 1;
    localparam logic [SW-1:0] S_LIMIT = SW'(FILTER);
    localparam logic [7:0]    CNT_MAX = 8'hFF;

    // -------------------------------------------------------------------------
    // Parameter legality. An out-of-range value stops elaboration rather than
    // building a silently wrong bank.
    // -------------------------------------------------------------------------
    if (DELAY < 1 || DELAY > 16) begin : g_bad_delay
        $error("nor_bank: DELAY must be in 1..16");
    end
    if (FILTER < 0 || FILTER > 255) begin : g_bad_filter
        $error("nor_bank: FILTER must be in 0..255");
    end
    if (CHANNELS < 1 || CHANNELS > 32) begin : g_bad_channels
        $error("nor_bank: CHANNELS must be in 1..32");
    end
    if (INPUTS < 1 || INPUTS > 16) begin : g_bad_inputs
        $error("nor_bank: INPUTS must be in 1..16");
    end

    // -------------------------------------------------------------------------
    // One fully independent slice per channel.
    // -------------------------------------------------------------------------
    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch

        logic             raw;      // unfiltered NOR of the enabled inputs
        logic             st_d;     // next filter state
        logic [SW-1:0]    s_q;      // consecutive edges raw has differed
        logic [SW-1:0]    s_d;
        logic             reject;   // a pending candidate dies on this edge
        logic [DELAY-1:0] stage_q;  // [0] = filter state, [DELAY-1] = y
        logic [DELAY-1:0] stage_d;
        logic             chg_q;
        logic             glitch_q;
        logic [7:0]       cnt_q;

        // Masking first, then NOR. A channel with every input disabled
        // therefore reads as 1.
        assign raw = ~|(in[c*INPUTS +: INPUTS] & en[c*INPUTS +: INPUTS]);

        // ---------------------------------------------------------------------
        // Persistence filter. The counter tracks how long raw has disagreed
        // with the accepted state. The change is taken on the edge where the
        // disagreement has already lasted FILTER edges. With FILTER = 0 that
        // is the first edge, so the filter reduces to a plain register of raw.
        // ---------------------------------------------------------------------
        always_comb begin
            // NOTE: every signal driven here gets a default before any branch,
            // so no path can leave one unassigned and infer a latch.
            st_d   = stage_q[0];
            s_d    = s_q;
            reject = 1'b0;
            if (raw == stage_q[0]) begin
                s_d    = '0;
                reject = (s_q != '0);
            end else if (s_q == S_LIMIT) begin
                st_d = raw;
                s_d  = '0;
            end else begin
                s_d = s_q + SW'(1);
            end
        end

        // ---------------------------------------------------------------------
        // Delay line. Stage 0 is the filter state. Every later stage copies
        // the stage before it.
        // ---------------------------------------------------------------------
        always_comb begin
            stage_d[0] = st_d;
            for (int i = 1; i < DELAY; i++) begin
                stage_d[i] = stage_q[i-1];
            end
        end

        // ---------------------------------------------------------------------
        // Filter state, delay line and output pulses.
        // chg compares the value the last stage is about to load with the
        // value it holds now. The registered pulse therefore lines up with
        // the first cycle y shows the new value. Shifting an equal value
        // through the delay line produces no pulse.
        // ---------------------------------------------------------------------
        // NOTE: state registers use non-blocking assignments, so every flop
        // samples pre-edge values no matter how the blocks are ordered.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                // NOTE: the delay line is ordinary flops and is reset with
                // everything else. Any change in flight is discarded instead
                // of surfacing on y after reset is released.
                stage_q  <= {DELAY{IV[c]}};
                s_q      <= '0;
                chg_q    <= 1'b0;
                glitch_q <= 1'b0;
            end else begin
                stage_q  <= stage_d;
                s_q      <= s_d;
                chg_q    <= stage_d[DELAY-1] ^ stage_q[DELAY-1];
                glitch_q <= reject;
            end
        end

        // ---------------------------------------------------------------------
        // Glitch counter. It saturates at 255. If a clear and an increment
        // land on the same edge, the clear wins. The glitch pulse above is
        // still issued in that case.
        // ---------------------------------------------------------------------
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt_q <= '0;
            end else if (clr_cnt) begin
                cnt_q <= '0;
            end else if (reject && cnt_q != CNT_MAX) begin
                cnt_q <= cnt_q + 8'd1;
            end
        end

        assign y[c]               = stage_q[DELAY-1];
        assign chg[c]             = chg_q;
        assign glitch[c]          = glitch_q;
        assign glitch_cnt[c*8 +: 8] = cnt_q;
    end

endmodule
